reel_stop_scheduler: RTL and testbench

REEL_STOP_SCHEDULER -- requirements
Module: reel_stop_scheduler

---
 rtl/reel_stop_scheduler.sv | 132 +++++++++++++
 tb/tb_reel_stop_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reel_stop_scheduler.sv
// Five-reel slot spin sequencer: spins all reels, stops them on staggered
// animation ticks, then scores the leftmost run of equal symbols.
module reel_stop_scheduler #(
  parameter int TICK_DIV       = 250000,
  parameter int MIN_SPIN_TICKS = 100,
  parameter int STAGGER_TICKS  = 30
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spin_req_i,
  input  logic [14:0] rnd_i,
  output logic        busy_o,
  output logic [4:0]  reel_spin_o,
  output logic        anim_step_o,
  output logic [2:0]  sym1_o,
  output logic [2:0]  sym2_o,
  output logic [2:0]  sym3_o,
  output logic [2:0]  sym4_o,
  output logic [2:0]  sym5_o,
  output logic        done_o,
  output logic        win_o,
  output logic [2:0]  match_cnt_o
);

  // A zero minimum spin still needs one tick before the first reel can stop.
  localparam int MIN_EFF = (MIN_SPIN_TICKS == 0) ? 1 : MIN_SPIN_TICKS;
  localparam int LAST    = MIN_EFF + 4 * STAGGER_TICKS;
  localparam int TW      = $clog2(LAST + 2);
  localparam int PW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SPIN, STOP, EVAL} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic [TW-1:0]   tick_cnt;
  logic [TW-1:0]   tick_num;
  logic            running;
  logic            tick;
  logic            start;
  logic [4:0]      stop_hit;
  logic [4:0]      reel_spin;
  logic [4:0][2:0] sym;
  logic [2:0]      mcnt;
  logic            run;

  assign running  = (state == SPIN) || (state == STOP);
  assign tick     = running && (presc == PW'(TICK_DIV - 1));
  assign tick_num = tick_cnt + TW'(1);
  // The done cycle is already IDLE, but a request there must not restart.
  assign start    = (state == IDLE) && spin_req_i && !done_o;

  for (genvar k = 0; k < 5; k++) begin : g_reel
    logic       spin;
    logic [2:0] sym_q;
    logic [2:0] field;

    assign field       = rnd_i[3*k +: 3];
    assign stop_hit[k] = tick && (tick_num == TW'(MIN_EFF + k * STAGGER_TICKS));

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        spin  <= 1'b0;
        sym_q <= '0;
      end else if (start) begin
        spin <= 1'b1;
      end else if (tick && spin) begin
        // Fold 6,7 onto 0,1 so every reel shows one of six symbols.
        sym_q <= (field > 3'd5) ? field - 3'd6 : field;
        if (stop_hit[k]) spin <= 1'b0;
      end
    end

    assign reel_spin[k] = spin;
    assign sym[k]       = sym_q;
  end

  always_comb begin
    mcnt = 3'd1;
    run  = 1'b1;
    for (int k = 1; k < 5; k++) begin
      run = run && (sym[k] == sym[0]);
      if (run) mcnt = mcnt + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      presc       <= '0;
      tick_cnt    <= '0;
      done_o      <= 1'b0;
      win_o       <= 1'b0;
      match_cnt_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state       <= SPIN;
          presc       <= '0;
          tick_cnt    <= '0;
          win_o       <= 1'b0;
          match_cnt_o <= '0;
        end
        SPIN, STOP: begin
          presc <= tick ? '0 : presc + PW'(1);
          if (tick) begin
            tick_cnt <= tick_num;
            if (stop_hit[4])      state <= EVAL;
            else if (stop_hit[0]) state <= STOP;
          end
        end
        EVAL: begin
          match_cnt_o <= mcnt;
          win_o       <= (mcnt >= 3'd3);
          done_o      <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = (state != IDLE);
  assign anim_step_o = tick;
  assign reel_spin_o = reel_spin;
  assign sym1_o      = sym[0];
  assign sym2_o      = sym[1];
  assign sym3_o      = sym[2];
  assign sym4_o      = sym[3];
  assign sym5_o      = sym[4];

endmodule

// File: tb/tb_reel_stop_scheduler.sv
// Bench for reel_stop_scheduler: a staggered instance and a zero-stagger
// instance share stimulus; a cycle-count model predicts every output.
module tb_reel_stop_scheduler;
  localparam int TD = 4;
  localparam int MS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spin_req = 1'b0;
  logic [14:0] rnd = '0;

  logic        busy [2];
  logic [4:0]  rspin [2];
  logic        anim [2];
  logic [2:0]  sym [2][5];
  logic        done [2];
  logic        win [2];
  logic [2:0]  mcnt [2];

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  reel_stop_scheduler #(.TICK_DIV(TD), .MIN_SPIN_TICKS(MS), .STAGGER_TICKS(2)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .spin_req_i(spin_req), .rnd_i(rnd),
    .busy_o(busy[0]), .reel_spin_o(rspin[0]), .anim_step_o(anim[0]),
    .sym1_o(sym[0][0]), .sym2_o(sym[0][1]), .sym3_o(sym[0][2]),
    .sym4_o(sym[0][3]), .sym5_o(sym[0][4]),
    .done_o(done[0]), .win_o(win[0]), .match_cnt_o(mcnt[0]));

  reel_stop_scheduler #(.TICK_DIV(TD), .MIN_SPIN_TICKS(MS), .STAGGER_TICKS(0)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .spin_req_i(spin_req), .rnd_i(rnd),
    .busy_o(busy[1]), .reel_spin_o(rspin[1]), .anim_step_o(anim[1]),
    .sym1_o(sym[1][0]), .sym2_o(sym[1][1]), .sym3_o(sym[1][2]),
    .sym4_o(sym[1][3]), .sym5_o(sym[1][4]),
    .done_o(done[1]), .win_o(win[1]), .match_cnt_o(mcnt[1]));

  task automatic chk(input string name, input int inst, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s[%0d] at %0t: got %0d, want %0d", name, inst, $time, act, exp);
    end
  endtask

  // Tick on which reel k (0-based) of instance i stops.
  function automatic int stop_tick(input int i, input int k);
    return MS + k * ((i == 0) ? 2 : 0);
  endfunction

  function automatic int last_cyc(input int i);
    return TD * stop_tick(i, 4);
  endfunction

  function automatic int fmap(input int v);
    return (v <= 5) ? v : v - 6;
  endfunction

  // Model: mn = index of the current cycle counted from acceptance (cycle 0),
  // or -1 when idle. Tick cycles are multiples of TD; reel 5 stops on cycle E,
  // evaluation happens on E+1 and done is seen on E+2.
  int mn [2] = '{-1, -1};
  int msym [2][5] = '{default: 0};
  int mwin [2] = '{0, 0};
  int mmatch [2] = '{0, 0};
  int un, ue, um;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        mn[i] = -1; mwin[i] = 0; mmatch[i] = 0;
        for (int k = 0; k < 5; k++) msym[i][k] = 0;
      end else if (mn[i] < 0) begin
        if (spin_req) begin
          mn[i] = 1; mwin[i] = 0; mmatch[i] = 0;
        end
      end else begin
        un = mn[i];
        ue = last_cyc(i);
        if (un <= ue && un % TD == 0)
          for (int k = 0; k < 5; k++)
            if (un / TD <= stop_tick(i, k)) msym[i][k] = fmap(int'(rnd[3*k +: 3]));
        if (un == ue + 1) begin
          um = 1;
          while (um < 5 && msym[i][um] == msym[i][0]) um++;
          mmatch[i] = um;
          mwin[i]   = (um >= 3) ? 1 : 0;
        end
        mn[i] = (un == ue + 2) ? -1 : un + 1;
      end
    end
  end

  int cn, ce, es;
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      cn = mn[i];
      ce = last_cyc(i);
      es = 0;
      for (int k = 0; k < 5; k++)
        if (cn >= 1 && cn <= TD * stop_tick(i, k)) es |= (1 << k);
      chk("busy", i, int'(busy[i]), (cn >= 1 && cn <= ce + 1) ? 1 : 0);
      chk("done", i, int'(done[i]), (cn == ce + 2) ? 1 : 0);
      chk("anim", i, int'(anim[i]), (cn >= 1 && cn <= ce && cn % TD == 0) ? 1 : 0);
      chk("reel_spin", i, int'(rspin[i]), es);
      chk("win", i, int'(win[i]), mwin[i]);
      chk("match_cnt", i, int'(mcnt[i]), mmatch[i]);
      for (int k = 0; k < 5; k++) chk("sym", i * 10 + k, int'(sym[i][k]), msym[i][k]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [14:0] syms_a();
    return {sym[0][4], sym[0][3], sym[0][2], sym[0][1], sym[0][0]};
  endfunction

  // One spin on both instances from idle; literal expectations for instance a.
  task automatic run_spin(input logic [14:0] r, input bit extra, input bit pins,
                          input int exp_match, input int exp_win, input logic [14:0] exp_syms);
    int da, db, nda;
    da = -1; db = -1; nda = 0;
    rnd = r;
    spin_req = 1'b1;
    if (pins) chk("busy_c0", 0, int'(busy[0]), 0);
    for (int c = 1; c <= 120; c++) begin
      cyc();
      spin_req = 1'b0;
      if (extra && c == 20) spin_req = 1'b1;
      if (done[0]) begin
        nda++;
        if (da < 0) da = c;
        if (extra && nda == 1) spin_req = 1'b1;
      end
      if (done[1] && db < 0) db = c;
      if (pins) begin
        if (c == 1)  chk("spin_c1", 0, int'(rspin[0]), 31);
        if (c == 3)  chk("anim_c3", 0, int'(anim[0]), 0);
        if (c == 4)  chk("anim_c4", 0, int'(anim[0]), 1);
        if (c == 12) chk("spin_c12", 0, int'(rspin[0]), 31);
        if (c == 13) chk("spin_c13", 0, int'(rspin[0]), 30);
        if (c == 12) chk("spin_c12", 1, int'(rspin[1]), 31);
        if (c == 13) chk("spin_c13", 1, int'(rspin[1]), 0);
      end
    end
    chk("done_cycle", 0, da, 46);
    chk("done_count", 0, nda, 1);
    chk("match_lit", 0, int'(mcnt[0]), exp_match);
    chk("win_lit", 0, int'(win[0]), exp_win);
    chk("syms_lit", 0, int'(syms_a()), int'(exp_syms));
    chk("idle_end", 0, int'(busy[0]), 0);
    if (pins) chk("done_cycle", 1, db, 14);
  endtask

  initial begin
    int nda;
    repeat (3) cyc();
    chk("rst_busy", 0, int'(busy[0]), 0);
    chk("rst_spin", 0, int'(rspin[0]), 0);
    chk("rst_syms", 0, int'(syms_a()), 0);
    chk("rst_match", 0, int'(mcnt[0]), 0);
    rst_n = 1'b1;
    cyc();

    run_spin(15'h0000, 1'b0, 1'b1, 5, 1, 15'h0000);
    run_spin({3'd2, 3'd3, 3'd2, 3'd2, 3'd2}, 1'b0, 1'b0, 3, 1, {3'd2, 3'd3, 3'd2, 3'd2, 3'd2});
    run_spin({3'd6, 3'd4, 3'd1, 3'd1, 3'd7}, 1'b0, 1'b0, 3, 1, {3'd0, 3'd4, 3'd1, 3'd1, 3'd1});
    run_spin({3'd1, 3'd1, 3'd1, 3'd2, 3'd1}, 1'b1, 1'b0, 1, 0, {3'd1, 3'd1, 3'd1, 3'd2, 3'd1});

    // Reset in the middle of a spin.
    nda = 0;
    rnd = {5{3'd3}};
    spin_req = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      cyc();
      spin_req = 1'b0;
      if (c == 30) rst_n = 1'b0;
      if (c == 33) rst_n = 1'b1;
      if (done[0]) nda++;
      if (c == 31) begin
        chk("abort_busy", 0, int'(busy[0]), 0);
        chk("abort_spin", 0, int'(rspin[0]), 0);
        chk("abort_syms", 0, int'(syms_a()), 0);
      end
    end
    chk("abort_nodone", 0, nda, 0);
    run_spin(15'h0000, 1'b0, 1'b0, 5, 1, 15'h0000);

    // Random traffic with per-cycle random words and occasional resets.
    for (int c = 0; c < 4000; c++) begin
      spin_req = ($urandom_range(0, 7) == 0);
      rnd = 15'($urandom);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        repeat ($urandom_range(1, 3)) cyc();
        rst_n = 1'b1;
      end
      cyc();
    end
    spin_req = 1'b0;
    repeat (4) cyc();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
